// File: rtl/avg_pkg.sv
// Shared AVG opcode definitions used by the sequencer front end and the field decoder.
package avg_pkg;

  typedef enum logic [2:0] {
    OP_VCTR  = 3'd0,
    OP_HALT  = 3'd1,
    OP_SVEC  = 3'd2,
    OP_STORE = 3'd3,
    OP_CNTR  = 3'd4,
    OP_JSR   = 3'd5,
    OP_RTS   = 3'd6,
    OP_JMP   = 3'd7
  } avg_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  localparam int VCTR_LEN  = 2;
  localparam int JADDR_MSB = 11;
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 13;

  function automatic logic [1:0] avg_inst_len(input avg_op_t op);
    return (op == OP_VCTR) ? 2'(VCTR_LEN) : 2'd1;
  endfunction

endpackage

// File: rtl/avg_ret_stack.sv
// JSR return-address LIFO: STACK_DEPTH entries of ADDR_W bits, top visible combinationally.
module avg_ret_stack #(
  parameter int STACK_DEPTH = 4,
  parameter int ADDR_W      = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [SPW-1:0]    sp_q;
  logic [SPW-1:0]    sp_d;
  logic [SPW-1:0]    top_idx;

  assign full_o  = (sp_q == SPW'(STACK_DEPTH));
  assign empty_o = (sp_q == '0);
  assign top_idx = sp_q - SPW'(1);
  assign top_o   = empty_o ? '0 : mem_q[IW'(top_idx)];

  always_comb begin
    sp_d = sp_q;
    if (clear_i) begin
      sp_d = '0;
    end else if (push_i && !full_o) begin
      sp_d = sp_q + SPW'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry storage needs no reset: nothing is visible until sp_q says so.
  always_ff @(posedge clk) begin
    if (rst_n && !clear_i && push_i && !full_o) begin
      mem_q[IW'(sp_q)] <= push_data_i;
    end
  end

endmodule

// File: rtl/avg_seq_fetch.sv
// AVG sequencer front end: prefetches vector memory, assembles 1/2-word instructions,
// executes JMP/JSR/RTS/HALT internally and hands data ops downstream over valid/ready.
module avg_seq_fetch
  import avg_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int FIFO_DEPTH  = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [2:0]        inst_op,
  output logic [15:0]       inst_w0,
  output logic [15:0]       inst_w1,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  // Handshake: an instruction transfers on a cycle where inst_valid && inst_ready at
  // posedge clk; once raised, inst_valid and all inst_* fields hold until that transfer.

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;
  logic              err_q, err_d;
  logic              rd_pend_q;

  logic [15:0]       fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [15:0]       head_w0, head_w1;
  avg_op_t           head_op;
  logic [1:0]        head_len;
  logic              head_ok;
  logic [ADDR_W-1:0] jtarget;
  logic [CW-1:0]     in_flight;

  logic              flush, fifo_push, fifo_pop, rd_en;
  logic              stk_push, stk_pop, stk_clear, stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top;

  assign head_w0   = fifo_q[rd_ptr_q];
  assign head_w1   = fifo_q[rd_ptr_q + PW'(1)];
  assign head_op   = avg_op_t'(head_w0[OP_MSB:OP_LSB]);
  assign head_len  = avg_inst_len(head_op);
  assign head_ok   = (state_q == ST_RUN) && (count_q >= CW'(head_len));
  assign jtarget   = ADDR_W'(head_w0[JADDR_MSB:0]);
  assign in_flight = count_q + CW'(rd_pend_q);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    head_pc_d = head_pc_q;
    err_d     = err_q;
    flush     = 1'b0;
    fifo_pop  = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clear = 1'b0;
    inst_valid = 1'b0;
    halted    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d   = ST_RUN;
          pc_d      = start_addr;
          head_pc_d = start_addr;
          err_d     = 1'b0;
          stk_clear = 1'b1;
        end
      end
      ST_RUN: begin
        if (head_ok) begin
          case (head_op)
            OP_JMP: begin
              flush     = 1'b1;
              pc_d      = jtarget;
              head_pc_d = jtarget;
            end
            OP_JSR: begin
              flush = 1'b1;
              if (stk_full) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end else begin
                stk_push  = 1'b1;
                pc_d      = jtarget;
                head_pc_d = jtarget;
              end
            end
            OP_RTS: begin
              flush = 1'b1;
              if (stk_empty) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end else begin
                stk_pop   = 1'b1;
                pc_d      = stk_top;
                head_pc_d = stk_top;
              end
            end
            OP_HALT: begin
              flush   = 1'b1;
              halted  = 1'b1;
              state_d = ST_IDLE;
            end
            default: begin
              inst_valid = 1'b1;
              if (inst_ready) begin
                fifo_pop  = 1'b1;
                head_pc_d = head_pc_q + ADDR_W'(head_len);
              end
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A flush cycle issues no read, so the only stale word is the one returning now.
    rd_en     = (state_q == ST_RUN) && !flush && (in_flight < CW'(FIFO_DEPTH));
    fifo_push = rd_pend_q && (state_q == ST_RUN) && !flush;
    if (rd_en) begin
      pc_d = pc_q + ADDR_W'(1);
    end

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (fifo_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(head_len);
      end
      count_d = count_q + (fifo_push ? CW'(1) : '0) - (fifo_pop ? CW'(head_len) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      head_pc_q <= '0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      head_pc_q <= head_pc_d;
      err_q     <= err_d;
      rd_pend_q <= rd_en;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && fifo_push && !flush) begin
      fifo_q[wr_ptr_q] <= mem_data;
    end
  end

  avg_ret_stack #(
    .STACK_DEPTH(STACK_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ret_stack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (stk_clear),
    .push_i     (stk_push),
    .pop_i      (stk_pop),
    .push_data_i(head_pc_q + ADDR_W'(1)),
    .top_o      (stk_top),
    .full_o     (stk_full),
    .empty_o    (stk_empty)
  );

  // Fields read zero whenever no instruction is offered.
  assign mem_rd   = rd_en;
  assign mem_addr = rd_en ? pc_q : '0;
  assign inst_op  = inst_valid ? head_w0[OP_MSB:OP_LSB] : 3'd0;
  assign inst_w0  = inst_valid ? head_w0 : 16'd0;
  assign inst_w1  = (inst_valid && head_op == OP_VCTR) ? head_w1 : 16'd0;
  assign inst_pc  = inst_valid ? head_pc_q : '0;
  assign busy     = (state_q == ST_RUN);
  assign err      = err_q;

endmodule

// File: tb/tb_avg_seq_fetch.sv
// Directed bench for avg_seq_fetch: synchronous memory model, per-scenario tasks.
module tb_avg_seq_fetch;

  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              go = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data = '0;
  logic              inst_valid;
  logic              inst_ready = 1'b1;
  logic [2:0]        inst_op;
  logic [15:0]       inst_w0;
  logic [15:0]       inst_w1;
  logic [ADDR_W-1:0] inst_pc;
  logic              busy;
  logic              halted;
  logic              err;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic [2:0]        op;
    logic [15:0]       w0;
    logic [15:0]       w1;
    logic [ADDR_W-1:0] pc;
  } inst_t;

  inst_t got_q[$];
  int    halt_cnt;
  int    idle_valid_cnt;

  logic [15:0] mem [0:8191];

  // Clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  avg_seq_fetch #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (4),
    .STACK_DEPTH(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .start_addr(start_addr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_op   (inst_op),
    .inst_w0   (inst_w0),
    .inst_w1   (inst_w1),
    .inst_pc   (inst_pc),
    .busy      (busy),
    .halted    (halted),
    .err       (err)
  );

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_prog(input logic [ADDR_W-1:0] addr);
    @(negedge clk);
    go = 1'b1;
    start_addr = addr;
    @(negedge clk);
    go = 1'b0;
  endtask

  // Collects accepted instructions and halted pulses until the sequencer drops busy.
  task automatic run_prog(input int max_cyc, output bit timed_out);
    got_q.delete();
    halt_cnt = 0;
    idle_valid_cnt = 0;
    timed_out = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      if (inst_valid && inst_ready) got_q.push_back({inst_op, inst_w0, inst_w1, inst_pc});
      if (halted) halt_cnt++;
      if (inst_valid && !busy) idle_valid_cnt++;
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [65:0] outs;
    outs = {mem_rd, mem_addr, inst_valid, inst_op, inst_w0, inst_w1, inst_pc, busy, halted, err};
    vec_cnt++;
    if (outs !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
  endtask

  task automatic test_svec_halt();
    bit to;
    inst_t exp_i;
    mem[13'h010] = 16'h4101;
    mem[13'h011] = 16'h2000;
    inst_ready = 1'b1;
    start_prog(13'h010);
    run_prog(100, to);
    vec_cnt++;
    if (to) begin err_cnt++; $display("FAIL svec_timeout: still busy after 100 cycles"); end
    vec_cnt++;
    if (got_q.size() != 1) begin
      err_cnt++;
      $display("FAIL svec_count: got %0d expected 1", got_q.size());
    end else begin
      exp_i = {3'd2, 16'h4101, 16'h0000, 13'h010};
      vec_cnt++;
      if (got_q[0] !== exp_i) begin
        err_cnt++;
        $display("FAIL svec_fields: got %h expected %h", got_q[0], exp_i);
      end
    end
    vec_cnt++;
    if (halt_cnt != 1) begin err_cnt++; $display("FAIL svec_halted: got %0d expected 1", halt_cnt); end
    vec_cnt++;
    if ({busy, err} !== 2'b00) begin err_cnt++; $display("FAIL svec_idle: busy,err got %b expected 00", {busy, err}); end
  endtask

  task automatic test_vctr_stall();
    bit to;
    int c;
    inst_t exp_i;
    mem[13'h020] = 16'h0005;
    mem[13'h021] = 16'h0003;
    mem[13'h022] = 16'h2000;
    exp_i = {3'd0, 16'h0005, 16'h0003, 13'h020};
    inst_ready = 1'b0;
    start_prog(13'h020);
    for (c = 0; c < 20; c++) begin
      if (inst_valid) break;
      @(negedge clk);
    end
    vec_cnt++;
    if (!inst_valid) begin err_cnt++; $display("FAIL vctr_valid: no inst_valid within 20 cycles"); end
    for (int k = 0; k < 10; k++) begin
      vec_cnt++;
      if ({inst_valid, inst_op, inst_w0, inst_w1, inst_pc} !== {1'b1, exp_i}) begin
        err_cnt++;
        $display("FAIL vctr_stall_hold[%0d]: got %b_%h expected 1_%h", k, inst_valid,
                 {inst_op, inst_w0, inst_w1, inst_pc}, exp_i);
      end
      @(negedge clk);
    end
    vec_cnt++;
    if (mem_rd !== 1'b0) begin err_cnt++; $display("FAIL vctr_fifo_full_rd: got %b expected 0", mem_rd); end
    inst_ready = 1'b1;
    run_prog(100, to);
    vec_cnt++;
    if (to || got_q.size() != 1 || halt_cnt != 1) begin
      err_cnt++;
      $display("FAIL vctr_drain: timeout %0d insts %0d halts %0d expected 0/1/1", to, got_q.size(), halt_cnt);
    end else begin
      vec_cnt++;
      if (got_q[0] !== exp_i) begin
        err_cnt++;
        $display("FAIL vctr_fields: got %h expected %h", got_q[0], exp_i);
      end
    end
  endtask

  task automatic test_jsr_rts();
    bit to;
    inst_t exp_i;
    mem[13'h000] = 16'hA100;
    mem[13'h001] = 16'h2000;
    mem[13'h002] = 16'h4222;
    mem[13'h100] = 16'h8000;
    mem[13'h101] = 16'hC000;
    inst_ready = 1'b1;
    start_prog(13'h000);
    run_prog(100, to);
    exp_i = {3'd4, 16'h8000, 16'h0000, 13'h100};
    vec_cnt++;
    if (to || got_q.size() != 1 || halt_cnt != 1 || err !== 1'b0) begin
      err_cnt++;
      $display("FAIL jsr_rts_flow: timeout %0d insts %0d halts %0d err %b expected 0/1/1/0",
               to, got_q.size(), halt_cnt, err);
    end else begin
      vec_cnt++;
      if (got_q[0] !== exp_i) begin
        err_cnt++;
        $display("FAIL jsr_rts_fields: got %h expected %h", got_q[0], exp_i);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    inst_t exp_a[4];
    mem[13'h400] = 16'h4001;
    mem[13'h401] = 16'h4002;
    mem[13'h402] = 16'h0007;
    mem[13'h403] = 16'h0008;
    mem[13'h404] = 16'h8003;
    mem[13'h405] = 16'h2000;
    exp_a[0] = {3'd2, 16'h4001, 16'h0000, 13'h400};
    exp_a[1] = {3'd2, 16'h4002, 16'h0000, 13'h401};
    exp_a[2] = {3'd0, 16'h0007, 16'h0008, 13'h402};
    exp_a[3] = {3'd4, 16'h8003, 16'h0000, 13'h404};
    inst_ready = 1'b1;
    start_prog(13'h400);
    run_prog(100, to);
    vec_cnt++;
    if (to || got_q.size() != 4) begin
      err_cnt++;
      $display("FAIL b2b_count: timeout %0d insts %0d expected 0/4", to, got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vec_cnt++;
        if (got_q[i] !== exp_a[i]) begin
          err_cnt++;
          $display("FAIL b2b_inst[%0d]: got %h expected %h", i, got_q[i], exp_a[i]);
        end
      end
    end
    vec_cnt++;
    if (idle_valid_cnt != 0) begin err_cnt++; $display("FAIL b2b_idle_valid: got %0d expected 0", idle_valid_cnt); end
  endtask

  task automatic test_pc_wrap();
    bit to;
    inst_t exp_i;
    mem[13'h1FFF] = 16'h4444;
    mem[13'h0000] = 16'h2000;
    inst_ready = 1'b1;
    start_prog(13'h1FFF);
    run_prog(100, to);
    exp_i = {3'd2, 16'h4444, 16'h0000, 13'h1FFF};
    vec_cnt++;
    if (to || got_q.size() != 1 || halt_cnt != 1) begin
      err_cnt++;
      $display("FAIL wrap_flow: timeout %0d insts %0d halts %0d expected 0/1/1", to, got_q.size(), halt_cnt);
    end else begin
      vec_cnt++;
      if (got_q[0] !== exp_i) begin
        err_cnt++;
        $display("FAIL wrap_fields: got %h expected %h", got_q[0], exp_i);
      end
    end
  endtask

  task automatic test_stack_overflow();
    bit to;
    int rd_seen;
    mem[13'h200] = 16'hA210;
    mem[13'h210] = 16'hA220;
    mem[13'h220] = 16'hA230;
    mem[13'h230] = 16'h4999;
    inst_ready = 1'b1;
    start_prog(13'h200);
    run_prog(100, to);
    vec_cnt++;
    if (to || {busy, err} !== 2'b01) begin
      err_cnt++;
      $display("FAIL ovf_err: timeout %0d busy,err %b expected 0/01", to, {busy, err});
    end
    vec_cnt++;
    if (got_q.size() != 0 || halt_cnt != 0) begin
      err_cnt++;
      $display("FAIL ovf_outputs: insts %0d halts %0d expected 0/0", got_q.size(), halt_cnt);
    end
    rd_seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (mem_rd) rd_seen++;
      @(negedge clk);
    end
    vec_cnt++;
    if (rd_seen != 0 || err !== 1'b1) begin
      err_cnt++;
      $display("FAIL ovf_quiet: reads %0d err %b expected 0/1", rd_seen, err);
    end
    start_prog(13'h010);
    vec_cnt++;
    if ({busy, err} !== 2'b10) begin
      err_cnt++;
      $display("FAIL ovf_go_clear: busy,err got %b expected 10", {busy, err});
    end
    run_prog(100, to);
    vec_cnt++;
    if (to || got_q.size() != 1 || halt_cnt != 1) begin
      err_cnt++;
      $display("FAIL ovf_rerun: timeout %0d insts %0d halts %0d expected 0/1/1", to, got_q.size(), halt_cnt);
    end
  endtask

  task automatic test_rts_underflow();
    bit to;
    mem[13'h300] = 16'hC000;
    mem[13'h301] = 16'h4555;
    start_prog(13'h300);
    run_prog(100, to);
    vec_cnt++;
    if (to || {busy, err} !== 2'b01 || got_q.size() != 0 || halt_cnt != 0) begin
      err_cnt++;
      $display("FAIL rts_underflow: timeout %0d busy,err %b insts %0d halts %0d expected 0/01/0/0",
               to, {busy, err}, got_q.size(), halt_cnt);
    end
  endtask

  task automatic test_jmp_loop_reset();
    int bad;
    int rd_seen;
    logic [65:0] outs;
    mem[13'h030] = 16'hE030;
    mem[13'h031] = 16'h4777;
    start_prog(13'h030);
    bad = 0;
    rd_seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (inst_valid || halted || !busy) bad++;
      if (mem_rd) rd_seen++;
      @(negedge clk);
    end
    vec_cnt++;
    if (bad != 0 || rd_seen == 0) begin
      err_cnt++;
      $display("FAIL jmp_loop: bad cycles %0d reads %0d expected 0/>0", bad, rd_seen);
    end
    rst_n = 1'b0;
    @(negedge clk);
    outs = {mem_rd, mem_addr, inst_valid, inst_op, inst_w0, inst_w1, inst_pc, busy, halted, err};
    vec_cnt++;
    if (outs !== '0) begin
      err_cnt++;
      $display("FAIL jmp_reset_outputs: got %h expected 0", outs);
    end
    rst_n = 1'b1;
    rd_seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_rd || busy) rd_seen++;
    end
    vec_cnt++;
    if (rd_seen != 0) begin
      err_cnt++;
      $display("FAIL jmp_post_reset_idle: active cycles %0d expected 0", rd_seen);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'h2000;
    do_reset();
    test_reset();
    test_svec_halt();
    test_vctr_stall();
    test_jsr_rts();
    test_back_to_back();
    test_pc_wrap();
    test_stack_overflow();
    test_rts_underflow();
    test_jmp_loop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/avg_seq_fetch.md
Name: avg_seq_fetch

Overview:
- Sequencer front end for the AVG vector pipeline.
- Fetches 16-bit words from vector memory into a prefetch FIFO, assembles 1- or 2-word instructions, and hands them to the downstream decode/draw stage over a valid/ready handshake.
- Executes JMP/JSR/RTS/HALT internally, using a parametrised return stack.
- Supersedes the single-word combinational decode path: the downstream stage only sees VCTR/SVEC/STAT/SCAL/CNTR.

Parameters:
- ADDR_W, 13, vector-memory word-address width.
- FIFO_DEPTH, 4, prefetch FIFO entries (16-bit words), power of 2, >=2.
- STACK_DEPTH, 4, JSR return-stack entries, >=1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- go  in  1  pulse: start execution at start_addr (ignored unless IDLE)
- start_addr  in  ADDR_W  program entry word address
- mem_rd  out  1  read strobe to synchronous vector memory
- mem_addr  out  ADDR_W  word address for mem_rd
- mem_data  in  16  read data, valid exactly 1 cycle after mem_rd
- inst_valid  out  1  assembled instruction available
- inst_ready  in  1  downstream accepts
- inst_op  out  3  opcode (avg_pkg::avg_op_t)
- inst_w0  out  16  first word
- inst_w1  out  16  second word (VCTR only, else 0)
- inst_pc  out  ADDR_W  word address of w0
- busy  out  1  state == RUN
- halted  out  1  one-cycle pulse when HALT is executed
- err  out  1  sticky: stack overflow/underflow; cleared only by reset or go

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all outputs 0; FIFO and stack empty; pc=0; any in-flight read dropped. Reset mid-fetch or mid-handshake aborts with no further output.
- Opcode = w0[15:13]: VCTR=0, HALT=1, SVEC=2, STORE=3, CNTR=4, JSR=5, RTS=6, JMP=7. Length is 2 words for VCTR, 1 for all others.
- Jump target = {zero-extend, w0[11:0]} (word address), truncated to ADDR_W.
- States:
  - IDLE: on go -> RUN, pc=start_addr, err=0, stack cleared.
  - RUN: stays RUN until HALT executes (-> IDLE) or an error occurs (-> IDLE with err=1).
- Fetch (RUN only):
  - mem_rd=1 when count + outstanding < FIFO_DEPTH and no flush this cycle.
  - mem_addr=pc; pc increments by 1 on each rd and wraps at 2^ADDR_W.
  - Returned data is pushed one cycle later unless tagged stale.
- Head processing, evaluated every RUN cycle on FIFO head:
  - VCTR needs count>=2; others need count>=1.
  - Data ops: inst_valid=1 with fields held stable until inst_ready. Pop on valid&&ready. Nothing else is consumed while stalled.
  - JMP: pop, pc=target, flush.
  - JSR: if stack full -> err=1, IDLE. Else push (inst_pc+1), pc=target, flush.
  - RTS: if stack empty -> err=1, IDLE. Else pop stack, pc=popped value, flush.
  - HALT: pop, halted pulse, flush, -> IDLE.
  - Control ops never assert inst_valid; each takes one cycle.
- Flush: FIFO emptied and outstanding read marked stale in the same cycle. The first refetch issues the next cycle, so the first post-jump instruction becomes valid no earlier than 3 cycles after the jump is at head.
- Simultaneous push+pop in one cycle is legal; count is unchanged.
- go while RUN is ignored.
- inst_pc wraps with pc.
- inst_valid must never assert in IDLE.

Decomposition:
- avg_pkg: avg_op_t enum (8 opcodes); localparams VCTR_LEN=2, JADDR_MSB=11, OP_MSB=15, OP_LSB=13; function avg_inst_len(op).
- Shared with the field decoder so both use one opcode definition.
- Sub-module avg_ret_stack (parametrised STACK_DEPTH × ADDR_W LIFO with push/pop/full/empty/clear).
- Prefetch FIFO stays inline: it needs a 2-entry peek.

Test Plan:
1. Reset then go, start_addr=0x010, mem: 0x010=0x4101 (SVEC), 0x011=0x2000 (HALT), inst_ready=1 -> one inst_valid with op=2, w0=0x4101, pc=0x010; then halted pulse; busy=0.
2. VCTR at 0x020: 0x0005, 0x0003 -> single inst_valid op=0, w0=0x0005, w1=0x0003, pc=0x020. Then inst_ready=0 for 10 cycles -> fields stable, no pop.
3. JSR at 0x000 = 0xA100 (target 0x100); 0x100=0x8000 (CNTR), 0x101=0xC000 (RTS); 0x001=0x2000 -> outputs CNTR pc=0x100, then HALT from 0x001; stale prefetch of 0x001.. before the JSR never emitted.
4. STACK_DEPTH=2, three nested JSRs without RTS -> err=1 on the third JSR, busy=0, no further mem_rd; then go -> err cleared.
5. RTS with empty stack at start_addr -> err=1, IDLE, no inst_valid.
6. JMP 0xE030 to self -> continuous loop with no inst_valid. Assert rst_n=0 mid-loop -> next cycle all outputs 0 and no mem_rd.
